// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg
//   Shared definitions for the byte serializer slice.
//   - ser_state_t : serializer FSM states (IDLE / SHIFT / GAP)
//   - bit_cnt_w() : width of the per-word bit counter for a given word width
//   - gap_cnt_w() : width of the inter-word gap counter for a given gap length
package byte_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } ser_state_t;

    // Counts 0..data_w-1; never narrower than one bit.
    function automatic int bit_cnt_w(input int data_w);
        return (data_w < 2) ? 1 : $clog2(data_w);
    endfunction

    // Counts 0..gap_cycles-1; a one-bit counter is kept even when the gap is unused.
    function automatic int gap_cnt_w(input int gap_cycles);
        return (gap_cycles < 2) ? 1 : $clog2(gap_cycles);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO, DATA_W x FIFO_DEPTH (FIFO_DEPTH a power of two).
//   Read data is presented combinationally from the head entry (show-ahead).
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (clears pointers and level)
//   push     in   write wr_data this cycle (ignored while full)
//   wr_data  in   DATA_W word to store
//   pop      in   discard head entry this cycle (ignored while empty)
//   rd_data  out  DATA_W head entry
//   level    out  current occupancy, 0..FIFO_DEPTH
//   full     out  level == FIFO_DEPTH
//   empty    out  level == 0
module sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty   = (level_q == '0);
    // A full FIFO refuses a push even if the head is popped in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_q];
    assign level   = level_q;

    // Pointers are exactly PTR_W bits, so they wrap modulo FIFO_DEPTH for free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage carries data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/byte_serializer.sv
// byte_serializer
//   Accepts parallel words over valid/ready, buffers them in a sync_fifo and
//   emits one bit per clock on ser_data with shift_enable high, so a downstream
//   serial-in register assembles one word per DATA_W enabled clocks.
//   Build option: define SER_LSB_FIRST_EN for LSB-first bit order (default MSB-first).
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-low reset
//   in_data       in   DATA_W word to serialize
//   in_valid      in   in_data valid this cycle
//   in_ready      out  FIFO can accept (0 while reset is asserted)
//   ser_data      out  current serial bit, 0 when shift_enable=0
//   shift_enable  out  high on every clock carrying a valid bit
//   byte_done     out  one-cycle pulse on the last bit of each word
//   busy          out  FSM not idle or FIFO non-empty
//   fifo_level    out  FIFO occupancy
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ser_data,
    output logic                          shift_enable,
    output logic                          byte_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_W = bit_cnt_w(DATA_W);
    localparam int GAP_W = gap_cnt_w(GAP_CYCLES);

    ser_state_t        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              last_bit;
    logic              gap_last;

    // Advance the shift register by one bit in the configured direction.
    function automatic logic [DATA_W-1:0] shift_next(input logic [DATA_W-1:0] v);
`ifdef SER_LSB_FIRST_EN
        return v >> 1;
`else
        return v << 1;
`endif
    endfunction

    // Bit currently presented by the shift register.
    function automatic logic out_bit(input logic [DATA_W-1:0] v);
`ifdef SER_LSB_FIRST_EN
        return v[0];
`else
        return v[DATA_W-1];
`endif
    endfunction

    // Ready looks at the registered level only, never at this cycle's pop.
    assign in_ready = reset && !fifo_full;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_valid && in_ready),
        .wr_data (in_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign last_bit = (bit_cnt_q == BIT_W'(DATA_W - 1));
    assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

    // Serial outputs decode from registers only, so there is no input-to-output path.
    assign shift_enable = (state_q == SHIFT);
    assign ser_data     = shift_enable && out_bit(shreg_q);
    assign byte_done    = shift_enable && last_bit;
    assign busy         = (state_q != IDLE) || !fifo_empty;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_rd_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                shreg_d   = shift_next(shreg_q);
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                if (last_bit) begin
                    bit_cnt_d = '0;
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else if (!fifo_empty) begin
                        // Back-to-back reload: next word starts with no bubble.
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rd_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            GAP: begin
                if (gap_last) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shreg_d   = fifo_rd_data;
                        bit_cnt_d = '0;
                        state_d   = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Control state: async reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Shift register holds data only; its value is masked whenever not shifting.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

endmodule
